// File: rtl/gelu_lut_rd_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// gelu_lut_rd_arbiter_pkg
// Shared sizing constants and types for the GELU LUT read-port arbiter.
// Also holds the half-word select used when a 32-bit LUT word is returned.
// Each LUT word packs two fp16 entries:
//   [31:16] is the negative-half entry, [15:0] is the positive-half entry.
// ---------------------------------------------------------------------------
package gelu_lut_rd_arbiter_pkg;

    localparam int GELU_LANES  = 4;
    localparam int LUT_ADDR_W  = 12;
    localparam int LUT_SRAM_AW = 13;

    typedef logic [LUT_ADDR_W-1:0] lut_addr_t;
    typedef logic [15:0]           fp16_t;

    // Pick the fp16 entry for a lookup from the packed 32-bit LUT word.
    function automatic fp16_t lut_half_sel(input logic [31:0] word, input logic sign);
        return sign ? word[31:16] : word[15:0];
    endfunction

endpackage

// File: rtl/gelu_lut_rd_arbiter_rr.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Generic round-robin arbiter. It is written to be reusable, for example by an
// ofmap-write arbiter.
//
// Ports
//   clk       in  1      clock
//   rst_n     in  1      async active-low reset; lane 0 becomes highest priority
//   req_i     in  N      request vector
//   advance_i in  1      current grant was accepted; move priority past it
//   gnt_o     out N      one-hot grant (all zero when there is no request)
//   idx_o     out IDX_W  encoded index of the granted requester
//   any_o     out 1      some requester is granted
//
// The search starts at the requester after the last accepted grant and wraps.
// The pointer resets to N-1, so requester 0 is searched first.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_i,
    input  logic             advance_i,
    output logic [N-1:0]     gnt_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] last_q;
    logic [IDX_W-1:0] last_d;

    // Rotating priority search, starting one past the last accepted grant.
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = 0; k < N; k++) begin
            logic [IDX_W-1:0] cand_s;
            logic             hit_s;
            cand_s        = IDX_W'((int'(last_q) + 1 + k) % N);
            hit_s         = !any_o && req_i[cand_s];
            gnt_o[cand_s] = gnt_o[cand_s] | hit_s;
            idx_o         = hit_s ? cand_s : idx_o;
            any_o         = any_o | hit_s;
        end
        last_d = (advance_i && any_o) ? idx_o : last_q;
    end

    // Last-grant pointer; reset value makes requester 0 the first searched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= IDX_W'(N - 1);
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/gelu_lut_rd_arbiter.sv
// ---------------------------------------------------------------------------
// gelu_lut_rd_arbiter
// Shares the single read port of the GELU LUT SRAM among N_LANES lanes.
// At most one read issues per cycle, granted round-robin.
// The read data comes back one cycle later. The selected fp16 half is then
// registered into the requesting lane's response slot, with a one-cycle
// rsp_valid pulse. Latency is 2 cycles from handshake to rsp_valid.
//
// Ports
//   clk, rst_n   clock, async active-low reset
//   req_valid    in  N_LANES             lane lookup pending
//   req_ready    out N_LANES             lane lookup accepted this cycle (one-hot)
//   req_addr     in  N_LANES*LUT_ADDR_W  per-lane LUT address
//   req_sign     in  N_LANES             1 selects [31:16], 0 selects [15:0]
//   rsp_valid    out N_LANES             pulse: rsp_data slice updated
//   rsp_data     out N_LANES*16          per-lane result, held until next response
//   lut_wr_busy  in  1                   host writing LUT; no new reads issue
//   sram_csb     out 1                   SRAM read chip-select, active low
//   sram_addr    out SRAM_ADDR_W         SRAM read address
//   sram_dout    in  32                  SRAM read data, one cycle after csb low
//   busy         out 1                   any request pending or a read in flight
// ---------------------------------------------------------------------------
module gelu_lut_rd_arbiter #(
    parameter int N_LANES     = gelu_lut_rd_arbiter_pkg::GELU_LANES,
    parameter int LUT_ADDR_W  = gelu_lut_rd_arbiter_pkg::LUT_ADDR_W,
    parameter int SRAM_ADDR_W = gelu_lut_rd_arbiter_pkg::LUT_SRAM_AW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_LANES-1:0]            req_valid,
    output logic [N_LANES-1:0]            req_ready,
    input  logic [N_LANES*LUT_ADDR_W-1:0] req_addr,
    input  logic [N_LANES-1:0]            req_sign,
    output logic [N_LANES-1:0]            rsp_valid,
    output logic [N_LANES*16-1:0]         rsp_data,
    input  logic                          lut_wr_busy,
    output logic                          sram_csb,
    output logic [SRAM_ADDR_W-1:0]        sram_addr,
    input  logic [31:0]                   sram_dout,
    output logic                          busy
);
    import gelu_lut_rd_arbiter_pkg::*;

    localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;

    logic [N_LANES-1:0]    arb_req_s;
    logic [N_LANES-1:0]    gnt_s;
    logic [IDX_W-1:0]      gnt_idx_s;
    logic                  gnt_any_s;
    logic [LUT_ADDR_W-1:0] gnt_addr_s;
    logic                  gnt_sign_s;

    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [SRAM_ADDR_W-1:0] addr_d;
    logic                   s1_valid_q;
    logic [IDX_W-1:0]       s1_lane_q;
    logic                   s1_sign_q;
    logic [N_LANES-1:0]     rsp_valid_q;
    fp16_t                  rsp_data_q [N_LANES];

    // A host LUT write blocks every new read, but not the one in flight.
    assign arb_req_s = req_valid & {N_LANES{~lut_wr_busy}};

    rr_arbiter #(
        .N     (N_LANES),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_i     (arb_req_s),
        .advance_i (gnt_any_s),
        .gnt_o     (gnt_s),
        .idx_o     (gnt_idx_s),
        .any_o     (gnt_any_s)
    );

    // Mux the granted lane's address/sign and drive the SRAM read port.
    // The address holds its last issued value while idle.
    always_comb begin
        gnt_addr_s = req_addr[gnt_idx_s*LUT_ADDR_W +: LUT_ADDR_W];
        gnt_sign_s = req_sign[gnt_idx_s];
        addr_d     = gnt_any_s ? SRAM_ADDR_W'(gnt_addr_s) : addr_q;
        sram_addr  = addr_d;
        sram_csb   = ~gnt_any_s;
        req_ready  = gnt_s;
    end

    // Last issued SRAM address plus the stage-1 tag of the read in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q     <= '0;
            s1_valid_q <= 1'b0;
            s1_lane_q  <= '0;
            s1_sign_q  <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            s1_valid_q <= gnt_any_s;
            s1_lane_q  <= gnt_idx_s;
            s1_sign_q  <= gnt_sign_s;
        end
    end

    // Response stage: pulse one valid bit and update only that lane's data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            for (int i = 0; i < N_LANES; i++) begin
                rsp_data_q[i] <= 16'h0000;
            end
        end else begin
            rsp_valid_q <= '0;
            if (s1_valid_q) begin
                rsp_valid_q[s1_lane_q] <= 1'b1;
                rsp_data_q[s1_lane_q]  <= lut_half_sel(sram_dout, s1_sign_q);
            end else begin
                rsp_valid_q <= '0;
            end
        end
    end

    for (genvar i = 0; i < N_LANES; i++) begin : g_rsp_pack
        assign rsp_data[i*16 +: 16] = rsp_data_q[i];
    end

    assign rsp_valid = rsp_valid_q;
    assign busy      = (|req_valid) | s1_valid_q;

endmodule
